disp_page_scheduler: RTL

- Time-shares the 4-digit display driver (display_16bto4h) between three sources of the adder/subtractor: operand A, operand B and the result.
- Sequences the pages, converts signed values to sign-magnitude, and drives the driver's x and neg inputs.
- Supports auto-rotation on a dwell counter and manual stepping from a raw push-button, with a blanking gap between pages.

---
 rtl/disp_pkg.sv | 43 ++++
 rtl/sync_edge.sv | 34 +++
 rtl/disp_page_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared encodings and helpers for the display page scheduler.
package disp_pkg;

   typedef enum logic [1:0] {
      SHOW_A = 2'd0,
      SHOW_B = 2'd1,
      SHOW_R = 2'd2,
      GAP    = 2'd3
   } page_state_t;

   localparam logic [2:0] PAGE_A    = 3'b001;
   localparam logic [2:0] PAGE_B    = 3'b010;
   localparam logic [2:0] PAGE_R    = 3'b100;
   localparam logic [2:0] PAGE_NONE = 3'b000;
   localparam logic [3:0] NEG_SIGN  = 4'b1000;

   typedef struct packed {
      logic [15:0] x;
      logic [3:0]  neg;
   } disp_t;

   function automatic page_state_t succ_page(page_state_t s);
      case (s)
         SHOW_A:  succ_page = SHOW_B;
         SHOW_B:  succ_page = SHOW_R;
         default: succ_page = SHOW_A;
      endcase
   endfunction

   // Sign-magnitude view; 16'h8000 negates to itself, which still reads as magnitude 8000.
   function automatic disp_t map_value(logic [15:0] v, logic sgn);
      disp_t d;
      if (sgn && v[15]) begin
         d.x   = (~v) + 16'd1;
         d.neg = NEG_SIGN;
      end else begin
         d.x   = v;
         d.neg = 4'b0000;
      end
      return d;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous level; optionally a rising-edge pulse.
// Latency: SYNC_STAGES cycles to the level output.
// No backpressure; the edge pulse is one cycle wide per low-to-high transition.
module sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE        = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '0;
      else     chain <= {chain[SYNC_STAGES-2:0], din};
   end

   generate
      if (EDGE) begin : g_edge
         logic prev;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) prev <= 1'b0;
            else     prev <= chain[SYNC_STAGES-1];
         end
         assign dout = chain[SYNC_STAGES-1] & ~prev;
      end else begin : g_level
         assign dout = chain[SYNC_STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/disp_page_scheduler.sv
// Time-shares the 4-digit display between operand A, operand B and the result.
// Latency: outputs registered, one cycle from state and live source values.
// No backpressure; pages advance on dwell expiry or a synchronised step edge.
module disp_page_scheduler
   import disp_pkg::*;
#(
   parameter int DWELL       = 50_000_000,
   parameter int BLANK_CYC   = 5_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] result,
   input  logic        ovf,
   input  logic        signed_mode,
   input  logic        auto_en,
   input  logic        step,
   input  logic        hold,
   output logic [15:0] x,
   output logic [3:0]  neg,
   output logic [2:0]  page,
   output logic        blank,
   output logic        ovf_flag
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int GW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

   logic step_rise, auto_s, hold_s;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_step_sync (
      .clk(CLK), .rst(RST), .din(step), .dout(step_rise)
   );
   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_auto_sync (
      .clk(CLK), .rst(RST), .din(auto_en), .dout(auto_s)
   );
   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_hold_sync (
      .clk(CLK), .rst(RST), .din(hold), .dout(hold_s)
   );

   page_state_t   state, state_n, next_page, next_page_n;
   logic [DW-1:0] dwell, dwell_n;
   logic [GW-1:0] gap, gap_n;
   logic          advance;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= SHOW_A;
         next_page <= SHOW_A;
         dwell     <= '0;
         gap       <= '0;
      end else begin
         state     <= state_n;
         next_page <= next_page_n;
         dwell     <= dwell_n;
         gap       <= gap_n;
      end
   end

   always_comb begin
      state_n     = state;
      next_page_n = next_page;
      dwell_n     = dwell;
      gap_n       = gap;
      advance     = 1'b0;
      if (state == GAP) begin
         // hold and step are deliberately ignored while blanking
         if (gap == GAP_LAST) begin
            state_n = next_page;
            gap_n   = '0;
         end else begin
            gap_n = gap + GW'(1);
         end
      end else begin
         advance = ~hold_s & ((auto_s & (dwell == DWELL_LAST)) | step_rise);
         if (advance) begin
            dwell_n = '0;
            if (BLANK_CYC > 0) begin
               state_n     = GAP;
               gap_n       = '0;
               next_page_n = succ_page(state);
            end else begin
               state_n = succ_page(state);
            end
         end else if (!auto_s) begin
            dwell_n = '0;
         end else if (!hold_s) begin
            dwell_n = dwell + DW'(1);
         end
      end
   end

   logic [15:0] src;
   disp_t       disp_n;
   logic [2:0]  page_n;
   logic        blank_n, ovf_flag_n;

   always_comb begin
      src        = a;
      page_n     = PAGE_A;
      blank_n    = 1'b0;
      ovf_flag_n = 1'b0;
      case (state)
         SHOW_B: begin
            src    = b;
            page_n = PAGE_B;
         end
         SHOW_R: begin
            src        = result;
            page_n     = PAGE_R;
            ovf_flag_n = ovf;
         end
         GAP: begin
            page_n  = PAGE_NONE;
            blank_n = 1'b1;
         end
         default: ;
      endcase
      disp_n = map_value(src, signed_mode);
      if (state == GAP) disp_n = '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         x        <= '0;
         neg      <= '0;
         page     <= PAGE_A;
         blank    <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         x        <= disp_n.x;
         neg      <= disp_n.neg;
         page     <= page_n;
         blank    <= blank_n;
         ovf_flag <= ovf_flag_n;
      end
   end

endmodule
